// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns (bit 6 = A ... bit 0 = G),
// capture FSM states and the error digit code.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_6_ALT = 7'b0011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_9_ALT = 7'b1110011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_ERR = 4'hF;

    typedef enum logic {
        SETTLING,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to BCD decoder; unknown patterns report BCD_ERR
// with isDigit_o low, the all-off pattern raises isBlank_o instead.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       isDigit_o,
    output logic       isBlank_o,
    output logic [3:0] bcd_o
);

    always_comb begin
        isDigit_o = 1'b1;
        isBlank_o = 1'b0;
        bcd_o     = BCD_ERR;
        unique case (pattern_i)
            SEG_0:            bcd_o = 4'd0;
            SEG_1:            bcd_o = 4'd1;
            SEG_2:            bcd_o = 4'd2;
            SEG_3:            bcd_o = 4'd3;
            SEG_4:            bcd_o = 4'd4;
            SEG_5:            bcd_o = 4'd5;
            SEG_6, SEG_6_ALT: bcd_o = 4'd6;
            SEG_7:            bcd_o = 4'd7;
            SEG_8:            bcd_o = 4'd8;
            SEG_9, SEG_9_ALT: bcd_o = 4'd9;
            SEG_BLANK: begin
                isDigit_o = 1'b0;
                isBlank_o = 1'b1;
            end
            default:          isDigit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Glitch-filtered seven-segment capture: registers the segment bus, waits for a
// stable pattern, decodes it and offers each new digit on a valid/ready register.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic       out_ready,
    output logic [3:0] out_bcd,
    output logic       out_valid,
    output logic       out_err,
    output logic       overrun
);

    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    state_t     state_q;
    logic [6:0] seg_q;
    logic [6:0] lastPat_q;
    logic [7:0] stabCnt_q;
    logic [7:0] stabCnt_d;
    logic [3:0] outBcd_q;
    logic       outValid_q;
    logic       outErr_q;
    logic       overrun_q;

    logic       sameSample;
    logic       settle;
    logic       emit;
    logic       load;
    logic       decIsDigit;
    logic       decIsBlank;
    logic [3:0] decBcd;

    seg7_decode uDecode (
        .pattern_i (seg_q),
        .isDigit_o (decIsDigit),
        .isBlank_o (decIsBlank),
        .bcd_o     (decBcd)
    );

    // Comparing the incoming sample against seg_q tells us whether the next
    // seg_q will match the current one, so a settle fires on the same edge.
    always_comb begin
        sameSample = (seg == seg_q);
        stabCnt_d  = 8'd0;
        if (sameSample) begin
            stabCnt_d = (stabCnt_q >= STAB_MAX) ? STAB_MAX : stabCnt_q + 8'd1;
        end
        settle = (state_q == SETTLING) && sameSample && (stabCnt_q == STAB_LAST);
        emit   = settle && (seg_q != lastPat_q) && !decIsBlank;
        load   = emit && (!outValid_q || out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SETTLING;
            seg_q      <= SEG_BLANK;
            lastPat_q  <= SEG_BLANK;
            stabCnt_q  <= 8'd0;
            outBcd_q   <= 4'h0;
            outValid_q <= 1'b0;
            outErr_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            seg_q     <= seg;
            stabCnt_q <= stabCnt_d;

            case (state_q)
                SETTLING: begin
                    if (settle) begin
                        state_q   <= HOLD;
                        lastPat_q <= seg_q;
                    end
                end
                HOLD: begin
                    if (!sameSample) begin
                        state_q <= SETTLING;
                    end
                end
                default: state_q <= SETTLING;
            endcase

            if (load) begin
                outValid_q <= 1'b1;
                outBcd_q   <= decBcd;
                outErr_q   <= !decIsDigit;
            end else if (outValid_q && out_ready) begin
                outValid_q <= 1'b0;
            end

            // A settled result with nowhere to go is lost; remember that until reset.
            if (emit && outValid_q && !out_ready) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign out_bcd   = outBcd_q;
    assign out_valid = outValid_q;
    assign out_err   = outErr_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Sequential seven-segment-to-BCD capture block: the decode direction of the BCD-to-seven-segment path. It watches a live active-high segment bus (A..G), filters glitches with a stability counter, and decodes each newly settled pattern back to a 4-bit BCD digit (W..Z). Each decoded digit is presented on a valid/ready output holding register. It sits between a display-drive point (or pin sampler) and a checker or logger, for closed-loop self-test of the display path.

## Interface
- STABLE_CYCLES, default 4: consecutive identical samples required before a pattern is accepted; legal range 1..255.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- seg  in  7  segment bus; bit 6 = A … bit 0 = G; 1 = segment lit.
- out_ready  in  1  consumer accepts out_bcd when high with out_valid.
- out_bcd  out  4  decoded digit; bit 3 = W (MSB) … bit 0 = Z.
- out_valid  out  1  out_bcd/out_err hold a pending result.
- out_err  out  1  pending result is an illegal pattern; out_bcd = 4'hF in that case.
- overrun  out  1  sticky; a settled result was dropped because the holding register was full.

## Operation
- Input register: seg is registered once (seg_q), and all decisions use seg_q.
- Stability counter stab_cnt (8 bits) increments while seg_q equals the previous cycle's seg_q, saturating at STABLE_CYCLES. It clears to 0 on any change.
- States:
  - SETTLING: waits for stab_cnt == STABLE_CYCLES-1 with an unchanged sample, then evaluates and enters HOLD.
  - HOLD: the pattern is accepted. Any change of seg_q returns to SETTLING.
- Evaluation of the settled pattern P (ABCDEFG):
  - 0 = 1111110.
  - 1 = 0110000.
  - 2 = 1101101.
  - 3 = 1111001.
  - 4 = 0110011.
  - 5 = 1011011.
  - 6 = 1011111 or 0011111.
  - 7 = 1110000.
  - 8 = 1111111.
  - 9 = 1111011 or 1110011.
  - Blank (0000000) produces no result.
  - Any other pattern produces an error result (out_err = 1, out_bcd = 4'hF).
- A result is produced only when P differs from last_pat, the last settled pattern. last_pat updates on every settle, including blank. Consequences: the same digit re-settling after a glitch does not re-emit; blank followed by the same digit does emit.
- Holding register behaviour:
  - Loads when empty, or when out_valid && out_ready in the same cycle (pass-through refill).
  - If full and not being drained, the result is dropped and overrun is set. overrun clears only on reset.

## Timing
- Reset values:
  - out_valid = 0, out_err = 0, out_bcd = 4'h0, overrun = 0.
  - state = SETTLING, stab_cnt = 0.
  - seg_q = 0, last_pat = 7'b0000000 (blank), so a blank bus after reset emits nothing.
- Latency: a pattern applied on seg at edge N (stable from then on) gives out_valid high after edge N+1+STABLE_CYCLES. With default 4, that is 5 cycles after the pattern first appears at the pin.
- out_valid stays high, with out_bcd and out_err stable, until the edge where out_ready = 1. It drops on that edge unless a new result loads on the same edge.
- A change of seg during settling restarts the count; a pattern held fewer than STABLE_CYCLES samples is never reported.
- Reset mid-settle or with a pending result discards everything and returns to the reset values on the next edge.
- STABLE_CYCLES = 1: a pattern settles on its first registered sample.

## Structure
- Shared package seg7_pkg holds:
  - the segment-pattern localparams SEG_0..SEG_9, SEG_6_ALT, SEG_9_ALT and SEG_BLANK (shared with the existing BCD-to-segment encoder);
  - the state enum {SETTLING, HOLD};
  - the BCD_ERR = 4'hF constant.
- One natural sub-module: seg7_decode, purely combinational. It maps 7 bits to {is_digit, is_blank, bcd[3:0]}.
- The top level keeps the input register, stability counter, FSM, last_pat, the holding register and overrun.

## Test plan
- Digit sweep: drive patterns 0..9 (primary encodings), each held 10 cycles, out_ready = 1 -> ten results with out_bcd 0..9 in order, out_err = 0, each valid exactly 1 cycle, 5 cycles after its pattern appears.
- Glitch rejection: hold 1111001 (3); insert 0110000 for 2 cycles; return to 3 -> no result for 1; no second result for 3.
- Illegal pattern: hold 1000001 for 8 cycles -> one result with out_err = 1, out_bcd = 4'hF.
- Blank re-arm: 8, then blank, then 8, each held 8 cycles -> two results of 4'h8; blank produces none.
- Backpressure: out_ready = 0; settle 2 then 5 -> out_bcd stays 2, 5 is dropped, overrun = 1. Raise out_ready -> out_valid drops the next cycle and overrun stays 1.
- Reset mid-operation: assert reset for 1 cycle with a pending result and a half-settled pattern -> all outputs at reset values next cycle. The pattern still on the bus re-settles and emits STABLE_CYCLES+1 cycles after reset deasserts.
